// File: rtl/exe_pkg.sv
// Shared constants for the execute stage: ALU command codes, branch types,
// iterative-unit FSM states and operation selector.
// Optional feature macro: EXE_REM_EN (adds the unsigned remainder command).
package exe_pkg;

   localparam int EXE_WIDTH  = 32;
   localparam int EXE_REG_AW = 5;

   // ALU command codes
   localparam logic [3:0] CMD_ADD = 4'b0000;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_AND = 4'b0100;
   localparam logic [3:0] CMD_OR  = 4'b0101;
   localparam logic [3:0] CMD_NOR = 4'b0110;
   localparam logic [3:0] CMD_XOR = 4'b0111;
   localparam logic [3:0] CMD_SLL = 4'b1000;
   localparam logic [3:0] CMD_SRA = 4'b1001;
   localparam logic [3:0] CMD_SRL = 4'b1010;
   localparam logic [3:0] CMD_MUL = 4'b1100;
   localparam logic [3:0] CMD_DIV = 4'b1101;
   localparam logic [3:0] CMD_REM = 4'b1110;

   // Branch types
   localparam logic [1:0] BR_NONE = 2'b00;
   localparam logic [1:0] BR_BEZ  = 2'b01;
   localparam logic [1:0] BR_BNE  = 2'b10;
   localparam logic [1:0] BR_JMP  = 2'b11;

   // Iterative unit FSM states
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Operation carried by the iterative unit
   typedef enum logic [1:0] {
      MD_MUL = 2'd0,
      MD_DIV = 2'd1,
      MD_REM = 2'd2
   } md_op_e;

endpackage

// File: rtl/exe_stage_muldiv_iter.sv
// Iterative multiply / divide unit. One shift-add (MUL) or restoring
// shift-subtract (DIV/REM) step per cycle, WIDTH steps per operation.
// The accumulator doubles as product (MUL) and partial remainder (DIV/REM);
// opa holds the shifting multiplicand or the dividend turning into quotient;
// opb holds the shifting multiplier or the constant divisor.
module muldiv_iter
   import exe_pkg::*;
#(
   parameter int WIDTH = EXE_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             kill,
   input  logic             start,
   input  md_op_e           op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [1:0]       state;
   md_op_e           op_q;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic [CW-1:0]    cnt;

   logic [WIDTH:0]   shifted;
   logic             fits;
   logic [WIDTH-1:0] sub;

   // Divider step: shift next dividend bit into the partial remainder and
   // test whether the divisor fits. A zero divisor always fits, which yields
   // an all-ones quotient and leaves the dividend as remainder.
   always_comb begin
      shifted = {acc, opa[WIDTH-1]};
      fits    = (shifted >= {1'b0, opb});
      sub     = shifted[WIDTH-1:0] - opb;
   end

   // Control FSM: IDLE -> BUSY (WIDTH steps) -> DONE -> IDLE; kill aborts.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else if (kill) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (start) state <= ST_BUSY;
            ST_BUSY: if (cnt == CW'(WIDTH - 1)) state <= ST_DONE;
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Datapath: capture operands on start, then one iteration per BUSY cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc  <= '0;
         opa  <= '0;
         opb  <= '0;
         cnt  <= '0;
         op_q <= MD_MUL;
      end else if (state == ST_IDLE && start && !kill) begin
         acc  <= '0;
         opa  <= a;
         opb  <= b;
         cnt  <= '0;
         op_q <= op;
      end else if (state == ST_BUSY) begin
         cnt <= cnt + 1'b1;
         if (op_q == MD_MUL) begin
            if (opb[0]) acc <= acc + opa;
            opa <= opa << 1;
            opb <= opb >> 1;
         end else begin
            acc <= fits ? sub : shifted[WIDTH-1:0];
            opa <= {opa[WIDTH-2:0], fits};
         end
      end
   end

   // Status and result selection
   always_comb begin
      busy   = (state == ST_BUSY);
      done   = (state == ST_DONE);
      result = (op_q == MD_DIV) ? opa : acc;
   end

endmodule

// File: rtl/exe_stage_muldiv.sv
// Execute stage with EXE/MEM output register. Single-cycle ALU and branch
// resolution; MUL/DIV (and REM when EXE_REM_EN is defined) go through the
// iterative unit and stall upstream until its DONE cycle, in which the held
// instruction is retired with the iterative result.
// Optional feature macro: EXE_REM_EN.
module exe_stage_muldiv
   import exe_pkg::*;
#(
   parameter int WIDTH  = EXE_WIDTH,
   parameter int REG_AW = EXE_REG_AW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              valid_in,
   input  logic [REG_AW-1:0] Dest_in,
   input  logic [WIDTH-1:0]  Reg2_in,
   input  logic [WIDTH-1:0]  Val1_in,
   input  logic [WIDTH-1:0]  Val2_in,
   input  logic [WIDTH-1:0]  PC_in,
   input  logic [1:0]        Br_type_in,
   input  logic [3:0]        EXE_CMD_in,
   input  logic              MEM_R_EN_in,
   input  logic              MEM_W_EN_in,
   input  logic              WB_EN_in,
   output logic              stall,
   output logic              busy,
   output logic              out_valid,
   output logic [WIDTH-1:0]  ALU_result,
   output logic              Br_taken,
   output logic [WIDTH-1:0]  Br_addr,
   output logic [REG_AW-1:0] Dest,
   output logic [WIDTH-1:0]  Reg2,
   output logic              MEM_R_EN,
   output logic              MEM_W_EN,
   output logic              WB_EN
);

   logic             is_md;
   md_op_e           md_op;
   logic             md_start;
   logic             md_busy;
   logic             md_done;
   logic [WIDTH-1:0] md_result;
   logic [WIDTH-1:0] alu_res;
   logic [WIDTH-1:0] br_target;
   logic             br_cond;
   logic [4:0]       shamt;

   // Decode which commands go to the iterative unit
   always_comb begin
      is_md = 1'b0;
      md_op = MD_MUL;
      case (EXE_CMD_in)
         CMD_MUL: begin is_md = 1'b1; md_op = MD_MUL; end
         CMD_DIV: begin is_md = 1'b1; md_op = MD_DIV; end
`ifdef EXE_REM_EN
         CMD_REM: begin is_md = 1'b1; md_op = MD_REM; end
`endif
         default: ;
      endcase
   end

   // Launch only from IDLE; while DONE the same instruction is still held
   // upstream and must not restart. Flush suppresses both launch and stall.
   always_comb begin
      md_start = valid_in && is_md && !md_busy && !md_done && !flush && !rst;
      stall    = !rst && !flush && (md_busy || md_start);
      busy     = md_busy;
   end

   muldiv_iter #(
      .WIDTH (WIDTH)
   ) u_muldiv (
      .clk    (clk),
      .rst    (rst),
      .kill   (flush),
      .start  (md_start),
      .op     (md_op),
      .a      (Val1_in),
      .b      (Val2_in),
      .busy   (md_busy),
      .done   (md_done),
      .result (md_result)
   );

   // Single-cycle ALU; unknown codes produce 0
   always_comb begin
      shamt   = Val2_in[4:0];
      alu_res = '0;
      case (EXE_CMD_in)
         CMD_ADD: alu_res = Val1_in + Val2_in;
         CMD_SUB: alu_res = Val1_in - Val2_in;
         CMD_AND: alu_res = Val1_in & Val2_in;
         CMD_OR:  alu_res = Val1_in | Val2_in;
         CMD_NOR: alu_res = ~(Val1_in | Val2_in);
         CMD_XOR: alu_res = Val1_in ^ Val2_in;
         CMD_SLL: alu_res = Val1_in << shamt;
         CMD_SRL: alu_res = Val1_in >> shamt;
         CMD_SRA: alu_res = $signed(Val1_in) >>> shamt;
         default: alu_res = '0;
      endcase
   end

   // Branch condition and target
   always_comb begin
      br_target = PC_in + (Val2_in << 2);
      case (Br_type_in)
         BR_BEZ:  br_cond = (Val1_in == '0);
         BR_BNE:  br_cond = (Val1_in != Reg2_in);
         BR_JMP:  br_cond = 1'b1;
         default: br_cond = 1'b0;
      endcase
   end

   // EXE/MEM register: bubble clears the control bits and holds data fields
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         ALU_result <= '0;
         Br_taken   <= 1'b0;
         Br_addr    <= '0;
         Dest       <= '0;
         Reg2       <= '0;
         MEM_R_EN   <= 1'b0;
         MEM_W_EN   <= 1'b0;
         WB_EN      <= 1'b0;
      end else if (flush || stall || !valid_in) begin
         out_valid <= 1'b0;
         Br_taken  <= 1'b0;
         MEM_R_EN  <= 1'b0;
         MEM_W_EN  <= 1'b0;
         WB_EN     <= 1'b0;
      end else begin
         out_valid  <= 1'b1;
         ALU_result <= md_done ? md_result : alu_res;
         Br_taken   <= br_cond;
         Br_addr    <= br_target;
         Dest       <= Dest_in;
         Reg2       <= Reg2_in;
         MEM_R_EN   <= MEM_R_EN_in;
         MEM_W_EN   <= MEM_W_EN_in;
         WB_EN      <= WB_EN_in;
      end
   end

endmodule
